apb_irq_ctrl: RTL

APB-slave interrupt controller that sits directly downstream of `gpio_module` and collects its per-pin `irq_o` pulses. It latches each pulse into a pending bit and masks it with a per-source enable. It then presents one level-sensitive interrupt request to the core. The core uses a claim/complete handshake: a read claims the highest-priority source, and a write releases it.

---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/apb_bus_t.sv | 37 +++
 rtl/irq_prio_enc.sv | 22 ++
 rtl/apb_irq_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the APB interrupt controller.
// Register offsets are byte offsets within the 32-byte window.
package irq_ctrl_pkg;

  localparam logic [4:0] IRQ_PENDING  = 5'h00;
  localparam logic [4:0] IRQ_ENABLE   = 5'h04;
  localparam logic [4:0] IRQ_STATUS   = 5'h08;
  localparam logic [4:0] IRQ_CLAIM    = 5'h0C;
  localparam logic [4:0] IRQ_COMPLETE = 5'h10;

  localparam int IRQ_CLAIM_VALID = 31;

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_SERVICE = 1'b1
  } irq_state_e;

endpackage

// File: rtl/apb_bus_t.sv
// APB3 bus bundle with clock and reset.
// Zero-wait slaves tie PREADY to the access phase.
interface apb_bus_t;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport slave (
    input  PCLK,
    input  PRESETn,
    input  PSEL,
    input  PENABLE,
    input  PWRITE,
    input  PADDR,
    input  PWDATA,
    output PRDATA,
    output PREADY
  );

  modport master (
    output PSEL,
    output PENABLE,
    output PWRITE,
    output PADDR,
    output PWDATA,
    input  PRDATA,
    input  PREADY
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder.
// Scanning downward lets the lowest set bit overwrite the result last.
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = i[4:0];
      end
    end
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB interrupt controller: pending/enable, lowest-index priority,
// single-source claim/complete handshake, registered core request.
module apb_irq_ctrl #(
  parameter int N_IRQS = 8
) (
  apb_bus_t.slave            apb_bus,
  input  logic [N_IRQS-1:0]  irq_i,
  output logic               irq_o
);

  import irq_ctrl_pkg::*;

  logic [N_IRQS-1:0] pending_q, pending_n;
  logic [N_IRQS-1:0] enable_q, enable_n;
  logic [4:0]        claimed_q, claimed_n;
  irq_state_e        state_q, state_n;
  logic              irq_q, irq_n;

  logic [N_IRQS-1:0] active;
  logic [N_IRQS-1:0] clr;
  logic [N_IRQS-1:0] one_hot;
  logic              best_valid;
  logic [4:0]        best;
  logic [31:0]       rdata;
  logic [31:0]       pend_w;
  logic [31:0]       en_w;
  logic [4:0]        offs;
  logic              acc;
  logic              wr;
  logic              rd;
  logic              unused_bits;

  assign active = pending_q & enable_q;

  irq_prio_enc #(
    .N (N_IRQS)
  ) u_prio (
    .req   (active),
    .valid (best_valid),
    .idx   (best)
  );

  always_comb begin
    pending_n = pending_q;
    enable_n  = enable_q;
    claimed_n = claimed_q;
    state_n   = state_q;
    rdata     = '0;
    clr       = '0;
    pend_w    = '0;
    en_w      = '0;
    pend_w[N_IRQS-1:0] = pending_q;
    en_w[N_IRQS-1:0]   = enable_q;
    one_hot    = '0;
    one_hot[0] = 1'b1;
    one_hot    = one_hot << best;
    acc  = apb_bus.PSEL && apb_bus.PENABLE;
    wr   = acc && apb_bus.PWRITE;
    rd   = acc && !apb_bus.PWRITE;
    offs = {apb_bus.PADDR[4:2], 2'b00};

    unique case (1'b1)
      offs == IRQ_PENDING: begin
        if (rd) rdata = pend_w;
        if (wr) clr = apb_bus.PWDATA[N_IRQS-1:0];
      end
      offs == IRQ_ENABLE: begin
        if (rd) rdata = en_w;
        if (wr) enable_n = apb_bus.PWDATA[N_IRQS-1:0];
      end
      offs == IRQ_STATUS: begin
        if (rd) begin
          rdata[0]    = (state_q == IRQ_SERVICE);
          rdata[12:8] = claimed_q;
        end
      end
      offs == IRQ_CLAIM: begin
        if (rd && state_q == IRQ_IDLE && best_valid) begin
          rdata[IRQ_CLAIM_VALID] = 1'b1;
          rdata[4:0] = best;
          clr        = one_hot;
          claimed_n  = best;
          state_n    = IRQ_SERVICE;
        end
      end
      offs == IRQ_COMPLETE: begin
        if (wr && state_q == IRQ_SERVICE &&
            apb_bus.PWDATA[4:0] == claimed_q)
          state_n = IRQ_IDLE;
      end
      default: ;
    endcase

    // A new request in the same cycle beats any clear.
    pending_n = (pending_q & ~clr) | irq_i;
    irq_n = (state_n == IRQ_IDLE) && |(pending_n & enable_n);
  end

  always_ff @(posedge apb_bus.PCLK or negedge apb_bus.PRESETn) begin
    if (!apb_bus.PRESETn) begin
      pending_q <= '0;
      enable_q  <= '0;
      claimed_q <= '0;
      state_q   <= IRQ_IDLE;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_n;
      enable_q  <= enable_n;
      claimed_q <= claimed_n;
      state_q   <= state_n;
      irq_q     <= irq_n;
    end
  end

  assign apb_bus.PRDATA = rdata;
  assign apb_bus.PREADY = apb_bus.PSEL && apb_bus.PENABLE;
  assign irq_o          = irq_q;

  assign unused_bits = ^{apb_bus.PADDR, apb_bus.PWDATA};

endmodule
